top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top_pkg.sv | 61 ++++++
 rtl/top_seg7_mux.sv | 55 +++++
 rtl/top.sv | 154 +++++++++++++++
 tb/tb_top.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/top_pkg.sv
// Shared types and constants for the periodic temperature sampler: state codes,
// interval table, tick/refresh periods for both timing modes, sensor latency.
package top_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_TEMP_START  = 4'd1,
        ST_TEMP_WAIT   = 4'd2,
        ST_DISPLAY     = 4'd3,
        ST_TIMER_START = 4'd4,
        ST_TIMER_WAIT  = 4'd5
    } state_t;

    localparam logic [3:0] INTERVAL_S [4] = '{4'd1, 4'd2, 4'd5, 4'd10};

    localparam int TICK_HW     = 10_000_000;
    localparam int TICK_SIM    = 1000;
    localparam int REFRESH_HW  = 8192;
    localparam int REFRESH_SIM = 4;
    localparam int SENSOR_LAT  = 16;

    function automatic int tick_period(input int sim);
        return (sim != 0) ? TICK_SIM : TICK_HW;
    endfunction

    function automatic int refresh_period(input int sim);
        return (sim != 0) ? REFRESH_SIM : REFRESH_HW;
    endfunction

    // Lowest set switch index wins; zero means "no selection".
    function automatic logic [3:0] interval_secs(input logic [3:0] sel);
        if (sel[0])      return INTERVAL_S[0];
        else if (sel[1]) return INTERVAL_S[1];
        else if (sel[2]) return INTERVAL_S[2];
        else if (sel[3]) return INTERVAL_S[3];
        else             return 4'd0;
    endfunction

    // Active-low cathodes, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_hex(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/top_seg7_mux.sv
// Eight-digit multiplexed seven-segment driver: digits 1:0 show the temperature,
// digits 5:4 the remaining seconds, all other digits are blanked.
module seg7_mux
    import top_pkg::*;
#(
    parameter int REFRESH = 8192
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] temp,
    input  logic [7:0] secs,
    output logic [6:0] seg,
    output logic [7:0] an
);

    localparam int CW = (REFRESH > 2) ? $clog2(REFRESH) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(REFRESH - 1);

    logic [CW-1:0] ref_cnt;
    logic [2:0]    digit;
    logic [3:0]    nib;
    logic          blank;

    always_comb begin
        nib   = 4'h0;
        blank = 1'b1;
        case (digit)
            3'd0: begin nib = temp[3:0]; blank = 1'b0; end
            3'd1: begin nib = temp[7:4]; blank = 1'b0; end
            3'd4: begin nib = secs[3:0]; blank = 1'b0; end
            3'd5: begin nib = secs[7:4]; blank = 1'b0; end
            default: ;
        endcase
    end

    // Anode and cathode are registered from the same digit index so they never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt <= RELOAD;
            digit   <= 3'd0;
            seg     <= 7'h7F;
            an      <= 8'hFF;
        end else begin
            if (ref_cnt == '0) begin
                ref_cnt <= RELOAD;
                digit   <= digit + 3'd1;
            end else begin
                ref_cnt <= ref_cnt - 1'b1;
            end
            an  <= ~(8'h01 << digit);
            seg <= blank ? 7'h7F : seg_hex(nib);
        end
    end

endmodule

// File: rtl/top.sv
// Periodic temperature sampler: measure, display, wait the selected interval, repeat.
// Build option: define TOP_LED_DEBUG_EN to mirror the state code on LED[15:12].
//
//  state        | meaning
//  IDLE         | no interval selected yet
//  TEMP_START   | one-cycle sensor start pulse
//  TEMP_WAIT    | waiting for sensor done
//  DISPLAY      | copy sensor data into the temperature register
//  TIMER_START  | load remaining seconds from the interval latch
//  TIMER_WAIT   | count seconds down, then sample again
module top
    import top_pkg::*;
#(
    parameter int Simulacion = 0
) (
    input  logic        clk_100,
    input  logic        reset,
    input  logic [15:0] SW,
    output logic [6:0]  SEG,
    output logic [7:0]  AN,
    output logic [15:0] LED,
    output logic [3:0]  st_dbg
);

    localparam logic [23:0] TICK_RELOAD = 24'(tick_period(Simulacion) - 1);
    localparam logic [4:0]  SENS_RELOAD = 5'(SENSOR_LAT - 1);

    logic clk_10MHz;

    generate
        if (Simulacion != 0) begin : g_sim_clk
            assign clk_10MHz = clk_100;
        end else begin : g_div_clk
            logic [2:0] div_cnt;
            logic       clk_div;
            always_ff @(posedge clk_100 or negedge reset) begin
                if (!reset) begin
                    div_cnt <= 3'd4;
                    clk_div <= 1'b0;
                end else if (div_cnt == 3'd0) begin
                    div_cnt <= 3'd4;
                    clk_div <= ~clk_div;
                end else begin
                    div_cnt <= div_cnt - 3'd1;
                end
            end
            assign clk_10MHz = clk_div;
        end
    endgenerate

    state_t      state;
    logic [3:0]  iv_latched;
    logic [3:0]  remaining;
    logic [7:0]  temp;
    logic [23:0] tick_cnt;
    logic        tick;
    logic [4:0]  sens_cnt;
    logic        sens_busy;
    logic        sens_done;
    logic [7:0]  sens_data;
    logic        timer_done;
    logic [3:0]  led_dbg;
    logic        sw_unused;

    assign sw_unused = ^SW[7:4];

    always_ff @(posedge clk_10MHz or negedge reset) begin
        if (!reset)              iv_latched <= 4'd0;
        else if (SW[3:0] != 4'd0) iv_latched <= interval_secs(SW[3:0]);
    end

    // Second tick restarts on timer load so the first second is always full length.
    always_ff @(posedge clk_10MHz or negedge reset) begin
        if (!reset)                        tick_cnt <= '0;
        else if (state == ST_TIMER_START)  tick_cnt <= TICK_RELOAD;
        else if (tick_cnt == '0)           tick_cnt <= TICK_RELOAD;
        else                               tick_cnt <= tick_cnt - 1'b1;
    end
    assign tick = (tick_cnt == '0);

    // Sensor stub: done exactly SENSOR_LAT cycles after the start pulse.
    always_ff @(posedge clk_10MHz or negedge reset) begin
        if (!reset) begin
            sens_busy <= 1'b0;
            sens_cnt  <= '0;
            sens_data <= 8'h00;
        end else begin
            if (state == ST_TEMP_START) begin
                sens_busy <= 1'b1;
                sens_cnt  <= SENS_RELOAD;
            end else if (sens_busy) begin
                if (sens_cnt == '0) sens_busy <= 1'b0;
                else                sens_cnt  <= sens_cnt - 1'b1;
            end
            if (sens_done) sens_data <= SW[15:8];
        end
    end
    assign sens_done = sens_busy && (sens_cnt == '0);

    assign timer_done = (state == ST_TIMER_WAIT) && tick && (remaining <= 4'd1);

    always_ff @(posedge clk_10MHz or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            remaining <= 4'd0;
            temp      <= 8'h00;
        end else begin
            case (state)
                ST_IDLE:        if (iv_latched != 4'd0) state <= ST_TEMP_START;
                ST_TEMP_START:  state <= ST_TEMP_WAIT;
                ST_TEMP_WAIT:   if (sens_done) state <= ST_DISPLAY;
                ST_DISPLAY: begin
                    temp  <= sens_data;
                    state <= ST_TIMER_START;
                end
                ST_TIMER_START: begin
                    remaining <= iv_latched;
                    state     <= ST_TIMER_WAIT;
                end
                ST_TIMER_WAIT: begin
                    if (timer_done) begin
                        remaining <= 4'd0;
                        state     <= ST_TEMP_START;
                    end else if (tick) begin
                        remaining <= remaining - 4'd1;
                    end
                end
                default:        state <= ST_IDLE;
            endcase
        end
    end

    assign st_dbg = state;

`ifdef TOP_LED_DEBUG_EN
    assign led_dbg = st_dbg;
`else
    assign led_dbg = 4'd0;
`endif

    assign LED = {led_dbg, 3'b000, (state == ST_TIMER_WAIT), temp};

    seg7_mux #(
        .REFRESH (refresh_period(Simulacion))
    ) u_seg7_mux (
        .clk   (clk_10MHz),
        .rst_n (reset),
        .temp  (temp),
        .secs  ({4'd0, remaining}),
        .seg   (SEG),
        .an    (AN)
    );

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top in simulation timing: vector table plus scoreboard of timer runs.
module tb_top;

    logic        clk_100;
    logic        reset;
    logic [15:0] SW;
    logic [6:0]  SEG;
    logic [7:0]  AN;
    logic [15:0] LED;
    logic [3:0]  st_dbg;

    top #(.Simulacion(1)) dut (
        .clk_100 (clk_100),
        .reset   (reset),
        .SW      (SW),
        .SEG     (SEG),
        .AN      (AN),
        .LED     (LED),
        .st_dbg  (st_dbg)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [3:0] sw_lo;
        logic [7:0] temp;
        int         secs;
    } vec_t;

    typedef struct {
        logic [7:0] temp;
        int         secs;
    } exp_t;

    vec_t vecs [5];
    exp_t sb_q [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: tracks every TIMER_WAIT run and compares it to the scoreboard on exit.
    int         run_len = 0;
    int         since_rst = 0;
    logic [3:0] prev_st = 4'd0;
    bit         led8_bad = 0;
    bit         an_bad = 0;
    bit         dbg_bad = 0;
    logic [3:0] exp_dbg;

    always @(negedge clk_100) begin
        if (!reset) begin
            run_len   = 0;
            since_rst = 0;
            prev_st   = 4'd0;
        end else begin
            since_rst++;
`ifdef TOP_LED_DEBUG_EN
            exp_dbg = st_dbg;
`else
            exp_dbg = 4'd0;
`endif
            if (LED[15:12] !== exp_dbg) dbg_bad = 1;
            if (LED[8] !== (st_dbg == 4'd5)) led8_bad = 1;
            if (LED[11:9] !== 3'b000) led8_bad = 1;
            if (since_rst > 1 && $countones(~AN) != 1) an_bad = 1;
            if (st_dbg == 4'd5) run_len++;
            if (prev_st == 4'd5 && st_dbg == 4'd1) begin
                if (sb_q.size() == 0) begin
                    check("run_expected", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("timer_len", 32'(run_len), 32'(e.secs * 1000));
                    check("led_temp", {24'd0, LED[7:0]}, {24'd0, e.temp});
                end
                run_len = 0;
            end
            prev_st = st_dbg;
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk_100);
        reset = 1'b1;
    endtask

    task automatic wait_st(input logic [3:0] s, input int budget, input string name);
        bit hit = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_100);
            if (st_dbg == s) begin hit = 1; break; end
        end
        check(name, {31'd0, hit}, 32'd1);
    endtask

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk_100);
            n++;
        end
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        if (sb_q.size() != 0) sb_q.delete();
    endtask

    task automatic check_digit(input string name, input logic [7:0] an_want, input logic [6:0] seg_want);
        bit         hit = 0;
        logic [6:0] s = 7'h00;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_100);
            if (AN == an_want) begin hit = 1; s = SEG; break; end
        end
        check({name, "_seen"}, {31'd0, hit}, 32'd1);
        if (hit) check(name, {25'd0, s}, {25'd0, seg_want});
    endtask

    task automatic run_vector(input vec_t v);
        int wl;
        exp_t e;
        do_reset();
        SW = {v.temp, 4'h0, v.sw_lo};
        e.temp = v.temp;
        e.secs = v.secs;
        sb_q.push_back(e);
        wait_st(4'd1, 10, "start_seen");
        wl = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_100);
            if (st_dbg == 4'd2) wl++;
            else break;
        end
        check("sensor_latency", 32'(wl), 32'd16);
        SW = {v.temp, 8'h00};
        repeat (5) @(negedge clk_100);
        check_digit("digit0", 8'hFE, HEX_SEG[v.temp[3:0]]);
        check_digit("digit1", 8'hFD, HEX_SEG[v.temp[7:4]]);
        check_digit("digit3", 8'hF7, 7'h7F);
        check_digit("digit4", 8'hEF, HEX_SEG[v.secs[3:0]]);
        check_digit("digit5", 8'hDF, HEX_SEG[0]);
        wait_sb(v.secs * 1000 + 200);
    endtask

    initial begin
        bit   idle_bad;
        exp_t e;

        vecs[0] = '{sw_lo: 4'h1, temp: 8'h2A, secs: 1};
        vecs[1] = '{sw_lo: 4'h6, temp: 8'h55, secs: 2};
        vecs[2] = '{sw_lo: 4'h4, temp: 8'hC3, secs: 5};
        vecs[3] = '{sw_lo: 4'h8, temp: 8'h0F, secs: 10};
        vecs[4] = '{sw_lo: 4'hC, temp: 8'hF0, secs: 5};

        reset = 1'b0;
        SW    = 16'h0000;
        repeat (3) @(negedge clk_100);
        check("rst_st",  {28'd0, st_dbg}, 32'd0);
        check("rst_led", {16'd0, LED},    32'd0);
        check("rst_seg", {25'd0, SEG},    32'h7F);
        check("rst_an",  {24'd0, AN},     32'hFF);

        reset = 1'b1;
        idle_bad = 0;
        repeat (1000) begin
            @(negedge clk_100);
            if (st_dbg != 4'd0 || LED != 16'h0000) idle_bad = 1;
        end
        check("idle_no_start", {31'd0, idle_bad}, 32'd0);
        check("idle_st", {28'd0, st_dbg}, 32'd0);

        for (int k = 0; k < 5; k++) run_vector(vecs[k]);

        // New selection mid-run applies only from the next timer load.
        do_reset();
        SW = 16'h2A01;
        e.temp = 8'h2A; e.secs = 1;
        sb_q.push_back(e);
        repeat (20) @(negedge clk_100);
        SW = 16'h2A00;
        wait_st(4'd5, 100, "first_wait_seen");
        repeat (100) @(negedge clk_100);
        SW = 16'h2A04;
        e.temp = 8'h2A; e.secs = 5;
        sb_q.push_back(e);
        repeat (20) @(negedge clk_100);
        SW = 16'h2A00;
        wait_sb(1000 + 5000 + 500);

        // Asynchronous abort in the middle of a timer run.
        wait_st(4'd5, 100, "abort_wait_seen");
        repeat (300) @(negedge clk_100);
        #2 reset = 1'b0;
        #1;
        check("abort_st",  {28'd0, st_dbg}, 32'd0);
        check("abort_led", {16'd0, LED},    32'd0);
        check("abort_seg", {25'd0, SEG},    32'h7F);
        check("abort_an",  {24'd0, AN},     32'hFF);
        repeat (3) @(negedge clk_100);
        reset = 1'b1;
        idle_bad = 0;
        repeat (200) begin
            @(negedge clk_100);
            if (st_dbg != 4'd0) idle_bad = 1;
        end
        check("abort_stays_idle", {31'd0, idle_bad}, 32'd0);
        check("abort_led_idle", {16'd0, LED}, 32'd0);

        check("led8_track", {31'd0, led8_bad}, 32'd0);
        check("an_onehot",  {31'd0, an_bad},   32'd0);
        check("led_dbg",    {31'd0, dbg_bad},  32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
